// File: rtl/nca_mc.sv
// Time-multiplexed CH-channel amplifier: slewed per-channel gain, one shared multiplier, saturating rescale.
// Latency: strobe edge to done/dataout commit is CH+3 cycles; one frame per CH+4 cycles at most.
// Backpressure: none; a strobe while busy is dropped, and dataout holds the last frame until the next commit.
module nca_mc #(
    parameter int DW      = 18,
    parameter int CW      = 18,
    parameter int CH      = 4,
    parameter int SLEW_SH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               strobe,
    input  logic               gain_snap,
    input  logic [CH*DW-1:0]   datain,
    input  logic [CH*CW-1:0]   ctrl,
    output logic [CH*DW-1:0]   dataout,
    output logic               busy,
    output logic               done
);

    localparam int PW   = DW + CW;
    localparam int IDXW = (CH > 1) ? $clog2(CH) : 1;
    localparam int CNTW = $clog2(CH + 3) + 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(CH + 2);
    localparam logic signed [DW-1:0] OMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] OMIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;
    logic   accept, last, issue;
    logic [CNTW-1:0] cnt;

    // captured frame inputs
    logic [CH*DW-1:0] din_q;
    logic [CH*CW-1:0] ctrl_q;
    logic             snap_q;

    // persistent per-channel gain
    logic signed [CW-1:0] cur [CH];

    // stage 1 combinational gain update
    logic [IDXW-1:0]      idx;
    logic signed [CW-1:0] tgt, cur_k, new_g;
    logic signed [CW:0]   diff, step;

    // pipeline registers
    logic                 s1_vld, s2_vld;
    logic [IDXW-1:0]      s1_idx, s2_idx;
    logic signed [DW-1:0] s1_smp;
    logic signed [CW-1:0] s1_gain;
    logic signed [PW-1:0] s2_prod;
    logic signed [PW-1:0] shifted;
    logic signed [DW-1:0] sat;
    logic [CH*DW-1:0]     sh;

    assign busy  = (state_q == RUN);
    assign issue = (state_q == RUN) && (cnt < CNTW'(CH));
    assign idx   = cnt[IDXW-1:0];

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state: accept only from idle, leave run once the last channel has been scaled
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // capture the frame so later input changes cannot leak in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q  <= '0;
            ctrl_q <= '0;
            snap_q <= 1'b0;
        end else if (accept) begin
            din_q  <= datain;
            ctrl_q <= ctrl;
            snap_q <= gain_snap;
        end
    end

    // frame cycle counter: channel issue index, then pipeline drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               cnt <= '0;
        else if (accept)          cnt <= '0;
        else if (state_q == RUN)  cnt <= cnt + 1'b1;
    end

    // gain slew: step toward target by diff>>>SLEW_SH, never stalling short of it
    always_comb begin
        tgt   = ctrl_q[idx*CW +: CW];
        cur_k = cur[idx];
        diff  = {tgt[CW-1], tgt} - {cur_k[CW-1], cur_k};
        step  = diff >>> SLEW_SH;
        if ((diff != '0) && (step == '0))
            step = diff[CW] ? '1 : (CW+1)'(1);
        new_g = snap_q ? tgt : CW'({cur_k[CW-1], cur_k} + step);
    end

    // per-channel gain state, written back as each channel passes stage 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CH; k++) cur[k] <= '0;
        end else if (issue) begin
            cur[idx] <= new_g;
        end
    end

    // stage 1 register: sample and updated gain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_idx  <= '0;
            s1_smp  <= '0;
            s1_gain <= '0;
        end else begin
            s1_vld <= issue;
            if (issue) begin
                s1_idx  <= idx;
                s1_smp  <= din_q[idx*DW +: DW];
                s1_gain <= new_g;
            end
        end
    end

    // stage 2: shared full-precision signed multiply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_idx  <= '0;
            s2_prod <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_idx  <= s1_idx;
                s2_prod <= PW'(s1_smp) * PW'(s1_gain);
            end
        end
    end

    // Q1 rescale by flooring shift; only -1.0 x -1.0 can exceed the output range
    always_comb begin
        shifted = s2_prod >>> (CW - 1);
        if (shifted > PW'(OMAX))      sat = OMAX;
        else if (shifted < PW'(OMIN)) sat = OMIN;
        else                          sat = shifted[DW-1:0];
    end

    // stage 3: park each result in its shadow slot until the whole frame is ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sh <= '0;
        else if (s2_vld) sh[s2_idx*DW +: DW] <= sat;
    end

    // atomic commit of all channels together with the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataout <= '0;
            done    <= 1'b0;
        end else begin
            done <= last;
            if (last) dataout <= sh;
        end
    end

endmodule

// File: tb/tb_nca_mc.sv
// Randomized and directed bench for nca_mc against a per-frame arithmetic model.
// Latency: each frame is expected to commit exactly CH+3 cycles after its strobe edge.
// Backpressure: strobes while busy must be dropped; dataout must hold until done.
module tb_nca_mc;

    localparam int DW      = 18;
    localparam int CW      = 18;
    localparam int CH      = 4;
    localparam int SLEW_SH = 4;
    localparam int FS      = 131072;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              strobe;
    logic              gain_snap;
    logic [CH*DW-1:0]  datain;
    logic [CH*CW-1:0]  ctrl;
    logic [CH*DW-1:0]  dataout;
    logic              busy;
    logic              done;

    int n_chk  = 0;
    int n_pass = 0;
    int mg[CH];    // model gain per channel
    int mout[CH];  // model committed output per channel

    always #5 clk = ~clk;

    nca_mc #(.DW(DW), .CW(CW), .CH(CH), .SLEW_SH(SLEW_SH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strobe    (strobe),
        .gain_snap (gain_snap),
        .datain    (datain),
        .ctrl      (ctrl),
        .dataout   (dataout),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int ch_out(input int k);
        logic signed [DW-1:0] v;
        v = dataout[k*DW +: DW];
        return int'(v);
    endfunction

    // gain after one frame: move 1/16 of the way, at least one LSB, or jump on snap
    function automatic int m_gain(input int cur, input int tgt, input bit snap);
        int diff, step;
        if (snap) return tgt;
        diff = tgt - cur;
        step = diff >>> SLEW_SH;
        if (diff != 0 && step == 0) step = (diff > 0) ? 1 : -1;
        return cur + step;
    endfunction

    // sample * gain / 2^(CW-1), floored, clamped to the sample range
    function automatic int m_amp(input int s, input int g);
        longint p, r;
        p = longint'(s) * longint'(g);
        r = p >>> (CW - 1);
        if (r > FS - 1) r = FS - 1;
        if (r < -FS)    r = -FS;
        return int'(r);
    endfunction

    function automatic int rnd_val();
        case ($urandom_range(7, 0))
            0:       return -FS;
            1:       return FS - 1;
            default: return int'($urandom_range(2*FS - 1, 0)) - FS;
        endcase
    endfunction

    task automatic drive(input int d[CH], input int c[CH], input bit snap);
        for (int k = 0; k < CH; k++) begin
            datain[k*DW +: DW] = DW'(d[k]);
            ctrl[k*CW +: CW]   = CW'(c[k]);
        end
        gain_snap = snap;
    endtask

    task automatic run_frame(input int d[CH], input int c[CH], input bit snap, input bit disturb);
        int prev[CH];
        int rd[CH];
        int rc[CH];
        int cyc;
        bit got;
        for (int k = 0; k < CH; k++) begin
            prev[k] = mout[k];
            mg[k]   = m_gain(mg[k], c[k], snap);
            mout[k] = m_amp(d[k], mg[k]);
        end
        @(negedge clk);
        drive(d, c, snap);
        strobe = 1'b1;
        @(posedge clk);
        #1;
        if (!disturb) strobe = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                got = 1'b1;
            end else begin
                for (int k = 0; k < CH; k++) check($sformatf("hold%0d", k), ch_out(k), prev[k]);
                check("busy", busy, 1);
                if (disturb) begin
                    for (int k = 0; k < CH; k++) begin
                        rd[k] = rnd_val();
                        rc[k] = rnd_val();
                    end
                    drive(rd, rc, $urandom_range(1, 0) == 1);
                end
            end
        end
        strobe = 1'b0;
        if (!got) check("done_timeout", 0, 1);
        check("latency", cyc, CH + 3);
        for (int k = 0; k < CH; k++) check($sformatf("out%0d", k), ch_out(k), mout[k]);
        check("busy_end", busy, 0);
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
    endtask

    initial begin
        int d[CH];
        int c[CH];
        int last0;

        rst_n     = 1'b0;
        strobe    = 1'b0;
        gain_snap = 1'b0;
        datain    = '0;
        ctrl      = '0;
        for (int k = 0; k < CH; k++) begin
            mg[k]   = 0;
            mout[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < CH; k++) check($sformatf("rst_out%0d", k), ch_out(k), 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // unity gain
        d = '{1000, -1000, 0, 131071};
        c = '{131071, 131071, 131071, 131071};
        run_frame(d, c, 1'b1, 1'b0);
        check("unity0", ch_out(0), 999);
        check("unity1", ch_out(1), -1000);
        check("unity2", ch_out(2), 0);
        check("unity3", ch_out(3), 131070);

        // saturation and sign handling
        d = '{-131072, 131071, -131072, 0};
        c = '{-131072, -131072, 131071, 0};
        run_frame(d, c, 1'b1, 1'b0);
        check("sat0", ch_out(0), 131071);
        check("sat1", ch_out(1), -131071);
        check("sat2", ch_out(2), -131071);

        // reset mid-frame, two cycles after the strobe edge
        d = '{500, 500, 500, 500};
        c = '{1000, 1000, 1000, 1000};
        @(negedge clk);
        drive(d, c, 1'b1);
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < CH; k++) check($sformatf("mid_rst_out%0d", k), ch_out(k), 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        for (int k = 0; k < CH; k++) begin
            mg[k]   = 0;
            mout[k] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;

        // slew from gain 0 toward 65536
        d = '{131071, 0, 0, 0};
        c = '{65536, 0, 0, 0};
        run_frame(d, c, 1'b0, 1'b0);
        check("slew_f1", ch_out(0), 4095);
        run_frame(d, c, 1'b0, 1'b0);
        check("slew_f2", ch_out(0), 7935);
        last0 = ch_out(0);
        for (int f = 0; f < 3; f++) begin
            run_frame(d, c, 1'b0, 1'b0);
            check("slew_mono", (ch_out(0) > last0) && (ch_out(0) < 65536), 1);
            last0 = ch_out(0);
        end

        // fine convergence upward: 1000 -> 1005 by one LSB per frame
        d = '{131071, 131071, 131071, 131071};
        c = '{1000, 1000, 1000, 1000};
        run_frame(d, c, 1'b1, 1'b0);
        c = '{1005, 1005, 1005, 1005};
        for (int f = 1; f <= 6; f++) begin
            run_frame(d, c, 1'b0, 1'b0);
            if (f == 1) check("fine_up_f1", ch_out(0), 1000);
            if (f == 4) check("fine_up_f4", ch_out(0), 1003);
            if (f == 5) check("fine_up_f5", ch_out(0), 1004);
            if (f == 6) check("fine_up_hold", ch_out(0), 1004);
        end

        // fine convergence downward: 1000 -> 995
        c = '{1000, 1000, 1000, 1000};
        run_frame(d, c, 1'b1, 1'b0);
        c = '{995, 995, 995, 995};
        for (int f = 1; f <= 6; f++) begin
            run_frame(d, c, 1'b0, 1'b0);
            if (f == 1) check("fine_dn_f1", ch_out(0), 998);
            if (f == 5) check("fine_dn_f5", ch_out(0), 994);
            if (f == 6) check("fine_dn_hold", ch_out(0), 994);
        end

        // strobe held high: exactly one done every CH+4 cycles
        d = '{12345, -54321, 77, -131072};
        c = '{-40000, 90000, 131071, 3};
        @(negedge clk);
        drive(d, c, 1'b1);
        strobe = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 3*(CH+4) - 1; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("thru_done_c%0d", i), done, (i % (CH+4)) == (CH+3));
        end
        strobe = 1'b0;
        for (int k = 0; k < CH; k++) begin
            mg[k]   = c[k];
            mout[k] = m_amp(d[k], c[k]);
            check($sformatf("thru_out%0d", k), ch_out(k), mout[k]);
        end
        @(posedge clk);
        #1;
        check("thru_idle", busy, 0);

        // randomized frames, some with mid-frame input churn and repeated strobes
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < CH; k++) begin
                d[k] = rnd_val();
                c[k] = rnd_val();
            end
            run_frame(d, c, $urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nca_mc.md
# nca_mc

Multi-channel, time-multiplexed numerically controlled amplifier with per-channel gain slewing and output saturation. It is the parametrised successor to the single 18×18 combinational NCA in the synth voice path. On each sample strobe it scales CH signed samples by CH signed gain words through one shared multiplier. Gain steps are smoothed (de-zippered) per channel, and results are shifted back to sample width with saturation. All CH outputs are presented atomically with a done pulse.

## Interface
Parameters:
- DW, 18: signed sample width.
- CW, 18: signed gain width. Q1.(CW-1) format; 2^(CW-1)-1 ≈ +1.0, -2^(CW-1) = -1.0.
- CH, 4: channel count, ≥1.
- SLEW_SH, 4: gain smoothing shift; 0 means gain jumps to target.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- strobe  in  1  start-of-frame request, one cycle.
- gain_snap  in  1  sampled with strobe; 1 = load targets directly, bypassing slew for this frame.
- datain  in  CH*DW  packed signed samples; channel k at [k*DW +: DW].
- ctrl  in  CH*CW  packed signed target gains; same packing.
- dataout  out  CH*DW  packed signed scaled samples; same packing.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when dataout updates.

## Operation
- States:
  - IDLE → RUN on strobe while idle.
  - RUN → IDLE after the last channel leaves stage 3.
  - strobe while busy is ignored (no queueing).
- Frame accepted: datain, ctrl and gain_snap are captured into input registers. Later input changes do not affect the frame.
- Per channel k, sequenced 0..CH-1, one channel issued per cycle, 3-stage pipeline:
  - S1, gain update on cur[k] (stored, reset 0). diff = tgt - cur, computed at CW+1 bits. step = diff >>> SLEW_SH (arithmetic). If diff ≠ 0 and step = 0, step = sign(diff)·1. new = snap ? tgt : cur + step. Write new back to cur[k]; register sample and new gain.
  - S2, multiply: prod = sample × gain, signed, DW+CW bits, registered.
  - S3, scale: r = prod >>> (CW-1) (floor). Saturate to [-2^(DW-1), 2^(DW-1)-1]. Write to shadow slot k.
- Commit: all shadow slots copy to dataout in the same edge that raises done. Between commits, dataout holds the previous frame.
- Negative gains are legal (phase inversion / ring-mod use).
- The only overflow case is full-scale negative × full-scale negative. It saturates to +max.

## Timing
- Edge E0 samples strobe=1 in IDLE.
- busy = 1 from after E0.
- Channel k passes S1 at E(k+1), S2 at E(k+2), S3 at E(k+3).
- dataout commit and done=1 at E(CH+3). busy falls at the same edge. done is high for exactly one cycle.
- Latency strobe→done: CH+3 cycles.
- Throughput: one frame per CH+4 cycles max. A strobe in the cycle done is high is accepted; a strobe earlier than that is ignored.
- Reset (asynchronous, any time, including mid-frame):
  - dataout=0, done=0, busy=0, all cur[k]=0, pipeline and shadow cleared, state IDLE.
  - The first strobe after rst_n rises is accepted normally.
- Gain state persists across frames. It changes only in S1 of an accepted frame or on reset.

## Test plan
Defaults DW=CW=18, CH=4, SLEW_SH=4.

1. **Reset:** assert rst_n=0 mid-frame, 2 cycles after strobe → dataout=0, busy=0, done=0 immediately. The next frame with snap=0 starts from gain 0.
2. **Unity:** snap=1, all ctrl=131071, datain ch0..3 = 1000, -1000, 0, 131071 → dataout 999, -1000, 0, 131070. done exactly 7 cycles after strobe edge.
3. **Saturation / sign:**
   - ch0 data=-131072, gain=-131072 → +131071.
   - ch1 131071 × -131072 → -131071.
   - ch2 -131072 × 131071 → -131071.
4. **Slew**, snap=0, from gain 0, ctrl=65536 on ch0, data=131071:
   - frame 1 gain 4096 → out 4095.
   - frame 2 gain 7936 → out 7935.
   - frames keep approaching 65536 monotonically.
5. **Fine convergence:** cur=1000, target 1005 → +1 per frame; reaches 1005 on frame 5 and stays there. Negative case: target 995 → -1 per frame.
6. **Busy rules:**
   - strobe repeated each cycle during a frame → exactly one done per CH+4 cycles.
   - datain changed mid-frame → no effect on the committed outputs.
   - dataout stable until the done edge.
